// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encoding for the common data bus arbiter.
package cdb_arbiter_pkg;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 4;
  localparam logic [CDB_TAG_W-1:0] CDB_NOT_RENAME = 4'b0000;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; full is registered and reflects the pre-edge count,
// so a push to a full FIFO is dropped even if the same edge pops it.
module cdb_src_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    if (rst || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
    end else if (rdy) begin
      // Pointers wrap for free because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      full_d   = (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    full_q   <= full_d;
    if (!rst && !flush && rdy && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = full_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB results onto one registered CDB via two FIFOs.
// CDB_FIXED_PRIO_EN: LSB always wins contention and the round-robin flop is dropped.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                 DATA_W     = CDB_DATA_W,
  parameter int                 TAG_W      = CDB_TAG_W,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [TAG_W-1:0]   NOT_RENAME = TAG_W'(CDB_NOT_RENAME)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_value,
  output logic              alu_full,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_full,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_src
);
  localparam int EW = TAG_W + DATA_W;

  logic          alu_empty, lsb_empty;
  logic [EW-1:0] alu_head, lsb_head;
  logic          grant_alu, grant_lsb;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  cdb_src_e          cdb_src_q, cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
  logic              rr_q, rr_d;
`endif

  cdb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(jump_wrong),
    .push(alu_valid && (alu_tag != NOT_RENAME)), .push_data({alu_tag, alu_value}),
    .pop(grant_alu), .full(alu_full), .empty(alu_empty), .head(alu_head)
  );

  cdb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(jump_wrong),
    .push(lsb_valid && (lsb_tag != NOT_RENAME)), .push_data({lsb_tag, lsb_value}),
    .pop(grant_lsb), .full(lsb_full), .empty(lsb_empty), .head(lsb_head)
  );

  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (!alu_empty && !lsb_empty) begin
`ifdef CDB_FIXED_PRIO_EN
      grant_lsb = 1'b1;
`else
      grant_lsb = rr_q;
      grant_alu = !rr_q;
`endif
    end else begin
      grant_alu = !alu_empty;
      grant_lsb = !lsb_empty;
    end
  end

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
`ifndef CDB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    if (rst) begin
      cdb_valid_d = 1'b0;
      cdb_tag_d   = NOT_RENAME;
      cdb_value_d = '0;
      cdb_src_d   = SRC_ALU;
`ifndef CDB_FIXED_PRIO_EN
      rr_d        = 1'b0;
`endif
    end else if (jump_wrong) begin
      cdb_valid_d = 1'b0;
    end else if (rdy) begin
      cdb_valid_d = grant_alu || grant_lsb;
      if (grant_lsb) begin
        {cdb_tag_d, cdb_value_d} = lsb_head;
        cdb_src_d = SRC_LSB;
      end else if (grant_alu) begin
        {cdb_tag_d, cdb_value_d} = alu_head;
        cdb_src_d = SRC_ALU;
      end
`ifndef CDB_FIXED_PRIO_EN
      // Fairness pointer only moves when both sources were waiting.
      if (!alu_empty && !lsb_empty) rr_d = !rr_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    cdb_valid_q <= cdb_valid_d;
    cdb_tag_q   <= cdb_tag_d;
    cdb_value_q <= cdb_value_d;
    cdb_src_q   <= cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
    rr_q        <= rr_d;
`endif
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model plus negedge monitor.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam logic [3:0] NR = 4'b0000;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic        src;
  } bc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b1, jump_wrong = 1'b0;
  logic        alu_valid = 1'b0, lsb_valid = 1'b0;
  logic [3:0]  alu_tag = '0, lsb_tag = '0;
  logic [31:0] alu_value = '0, lsb_value = '0;
  logic        alu_full, lsb_full, cdb_valid, cdb_src;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit saw_full = 1'b0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each source is a plain queue of results, the CDB a set of registers.
  bc_t aq[$], lq[$], exp_q[$];
  bit  m_rr = 1'b0, m_valid = 1'b0, m_src = 1'b0, m_new = 1'b0;
  bit  m_afull = 1'b0, m_lfull = 1'b0;
  logic [3:0]  m_tag = NR;
  logic [31:0] m_value = '0;

  always @(posedge clk) begin
    bc_t e;
    bit a_in, l_in, ga, gl;
    m_new = 1'b0;
    if (rst) begin
      aq.delete(); lq.delete();
      m_rr = 1'b0; m_valid = 1'b0; m_tag = NR; m_value = '0; m_src = 1'b0;
    end else if (jump_wrong) begin
      aq.delete(); lq.delete();
      m_valid = 1'b0;
    end else if (rdy) begin
      a_in = alu_valid && !m_afull && alu_tag != NR;
      l_in = lsb_valid && !m_lfull && lsb_tag != NR;
      ga = 1'b0; gl = 1'b0;
      if (aq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_FIXED_PRIO_EN
        gl = 1'b1;
`else
        if (m_rr) gl = 1'b1; else ga = 1'b1;
        m_rr = !m_rr;
`endif
      end else if (aq.size() > 0) ga = 1'b1;
      else if (lq.size() > 0) gl = 1'b1;
      if (ga) e = aq.pop_front();
      else if (gl) e = lq.pop_front();
      m_valid = ga || gl;
      if (m_valid) begin
        m_tag = e.tag; m_value = e.value; m_src = e.src;
        exp_q.push_back(e);
        m_new = 1'b1;
      end
      if (a_in) aq.push_back('{tag: alu_tag, value: alu_value, src: 1'b0});
      if (l_in) lq.push_back('{tag: lsb_tag, value: lsb_value, src: 1'b1});
    end
    m_afull = (aq.size() == DEPTH);
    m_lfull = (lq.size() == DEPTH);
  end

  // Monitor: every fresh broadcast consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    bc_t e;
    if (mon_en) begin
      saw_full = saw_full || alu_full;
      chk("cdb_valid", cdb_valid, m_valid);
      chk("cdb_tag", cdb_tag, m_tag);
      chk("cdb_value", cdb_value, m_value);
      chk("cdb_src", cdb_src, m_src);
      chk("alu_full", alu_full, m_afull);
      chk("lsb_full", lsb_full, m_lfull);
      if (m_new) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_bcast", {cdb_valid, cdb_src, cdb_tag, cdb_value}, {1'b1, e.src, e.tag, e.value});
        end
      end
    end
  end

  task automatic drive(input logic av, input logic [3:0] at, input logic [31:0] avl,
                       input logic lv, input logic [3:0] lt, input logic [31:0] lvl,
                       input logic jw = 1'b0, input logic r = 1'b1, input logic rs = 1'b0);
    alu_valid = av; alu_tag = at; alu_value = avl;
    lsb_valid = lv; lsb_tag = lt; lsb_value = lvl;
    jump_wrong = jw; rdy = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  logic [3:0] first_a, second_a, first_b, second_b;

  initial begin
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_tag", cdb_tag, NR);
    chk("rst_value", cdb_value, 0);
    chk("rst_src", cdb_src, 0);
    chk("rst_full", {alu_full, lsb_full}, 0);

    // Single source: one-cycle latency, single-cycle pulse.
    drive(1'b1, 4'd3, 32'h11, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("single_no_bypass", cdb_valid, 0);
    idle();
    @(negedge clk);
    chk("single_bcast", {cdb_valid, cdb_src, cdb_tag, cdb_value}, {1'b1, 1'b0, 4'd3, 32'h11});
    idle();
    @(negedge clk);
    chk("single_pulse_end", cdb_valid, 0);

    // Contention, rr starts at ALU after reset.
    do_reset();
`ifdef CDB_FIXED_PRIO_EN
    first_a = 4'd2; second_a = 4'd1; first_b = 4'd5; second_b = 4'd4;
`else
    first_a = 4'd1; second_a = 4'd2; first_b = 4'd5; second_b = 4'd4;
`endif
    drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
    idle(); @(negedge clk); chk("cont1_first", cdb_tag, first_a);
    idle(); @(negedge clk); chk("cont1_second", cdb_tag, second_a);
    drive(1'b1, 4'd4, 32'h4, 1'b1, 4'd5, 32'h5);
    idle(); @(negedge clk); chk("cont2_first", cdb_tag, first_b);
    idle(); @(negedge clk); chk("cont2_second", cdb_tag, second_b);
    idle();

    // rdy stall holds the CDB, then resumes with the next entry.
    drive(1'b1, 4'd6, 32'h66, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 4'd7, 32'h77, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("stall_hold", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 4'd6, 32'h66});
    end
    idle(); @(negedge clk);
    chk("stall_resume", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 4'd7, 32'h77});
    idle();

    // Flush with results queued and a same-cycle push.
    drive(1'b1, 4'd1, 32'h101, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 4'd2, 32'h102, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 4'd3, 32'h103, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 4'd9, 32'h999, 1'b0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_quiet", {cdb_valid, alu_full}, 0);
      idle();
    end

    // Tag filter: NOT_RENAME is never queued.
    drive(1'b0, 4'h0, 32'h0, 1'b1, NR, 32'hDEAD);
    idle(); @(negedge clk); chk("nr_filter", cdb_valid, 0);
    idle(); @(negedge clk); chk("nr_filter2", cdb_valid, 0);

    // Backpressure: both sources at rate 1, pushes while full dropped.
    do_reset();
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++)
      drive(1'b1, 4'(1 + i % 15), 32'h1000 + 32'(i), 1'b1, 4'(1 + (i + 7) % 15), 32'h2000 + 32'(i));
    for (int i = 0; i < 12; i++) idle();
    @(negedge clk);
    chk("bp_alu_full_seen", saw_full, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 39) == 0, $urandom_range(0, 19) < 17,
            $urandom_range(0, 499) == 0);
    end
    for (int i = 0; i < 20; i++) idle();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
